// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter with packet locking for a NOC output port.
// Holds a grant until the tail beat, a withdrawal, or the optional hold watchdog fires.
module rr_arbiter_lock #(
  parameter int unsigned NUM_REQ  = 5,
  parameter int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  input  logic               ready_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o,
  output logic               timeout_o
);

  localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   ptr_after;
  logic [IDX_W-1:0]   scan_start;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               rel_withdraw, rel_tail, rel_timeout, release_grant;

  // Pointer value that follows a release of the current winner.
  always_comb begin
    if (32'(idx_q) == NUM_REQ - 1) begin
      ptr_after = '0;
    end else begin
      ptr_after = idx_q + IDX_W'(1);
    end
  end

  // On a release the same edge re-arbitrates, so scan from the rotated pointer.
  assign scan_start = (state_q == StBusy) ? ptr_after : ptr_q;

  always_comb begin : sel_scan
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(scan_start) + k) % NUM_REQ;
      if (!sel_found && req_i[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  // Release causes in priority order: withdrawal, tail beat, watchdog.
  assign rel_withdraw  = !req_i[idx_q];
  assign rel_tail      = !rel_withdraw && ready_i && last_i[idx_q];
  assign rel_timeout   = (MAX_HOLD != 0) && !rel_withdraw && !rel_tail &&
                         (hold_cnt_q == HoldLast);
  assign release_grant = rel_withdraw || rel_tail || rel_timeout;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        hold_cnt_d = '0;
        if (sel_found) begin
          state_d = StBusy;
          grant_d = NUM_REQ'(1) << sel_idx;
          idx_d   = sel_idx;
        end
      end
      StBusy: begin
        if (release_grant) begin
          ptr_d      = ptr_after;
          timeout_d  = rel_timeout;
          hold_cnt_d = '0;
          if (sel_found) begin
            grant_d = NUM_REQ'(1) << sel_idx;
            idx_d   = sel_idx;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
          end
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    grant_o       = grant_q;
    grant_idx_o   = idx_q;
    grant_valid_o = (state_q == StBusy);
    timeout_o     = timeout_q;
  end

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(grant_q));
  a_valid_matches : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    grant_valid_o == (grant_q != '0));
`endif

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed bench for rr_arbiter_lock: vector table plus hand-written multi-cycle sequences.
module tb_rr_arbiter_lock;

  logic       clk;
  logic       rst_n;
  logic [4:0] req, last;
  logic       ready;
  logic [4:0] grant;
  logic [2:0] gidx;
  logic       gvalid, tmo;

  logic [4:0] req_b, last_b;
  logic       ready_b;
  logic [4:0] grant_b;
  logic [2:0] gidx_b;
  logic       gvalid_b, tmo_b;

  int checks = 0;
  int errors = 0;

  rr_arbiter_lock dut_a (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req),
    .last_i       (last),
    .ready_i      (ready),
    .grant_o      (grant),
    .grant_idx_o  (gidx),
    .grant_valid_o(gvalid),
    .timeout_o    (tmo)
  );

  rr_arbiter_lock #(.MAX_HOLD(8)) dut_b (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req_b),
    .last_i       (last_b),
    .ready_i      (ready_b),
    .grant_o      (grant_b),
    .grant_idx_o  (gidx_b),
    .grant_valid_o(gvalid_b),
    .timeout_o    (tmo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic [4:0] last;
    logic       ready;
    logic [4:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed compare of {grant, idx, valid, timeout}.
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {grant,idx,valid,tmo}=%b required %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1; req = '0; last = '0; ready = 1'b0;
    req_b = '0; last_b = '0; ready_b = 1'b0;

    // Test 1 (N,L then tail), test 3 (held tail without ready), test 4 (withdraw).
    tbl[0]  = '{5'b10001, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{5'b10001, 5'b00001, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
    tbl[2]  = '{5'b10000, 5'b10000, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
    tbl[3]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{5'b10001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[5]  = '{5'b10001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[6]  = '{5'b10001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[7]  = '{5'b10001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[8]  = '{5'b10001, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{5'b10001, 5'b00001, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
    tbl[10] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
    tbl[12] = '{5'b00110, 5'b00010, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
    tbl[13] = '{5'b00010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0};
    tbl[14] = '{5'b00010, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0};
    tbl[15] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0};

    #3;
    rst_n = 1'b0;
    #1;
    check("reset_a", {grant, gidx, gvalid, tmo}, 10'b0);
    check("reset_b", {grant_b, gidx_b, gvalid_b, tmo_b}, 10'b0);
    #8;
    rst_n = 1'b1;
    #1;
    tick();
    check("idle_no_req", {grant, gidx, gvalid, tmo}, 10'b0);

    for (int i = 0; i < 16; i++) begin
      req   = tbl[i].req;
      last  = tbl[i].last;
      ready = tbl[i].ready;
      tick();
      check($sformatf("vec%0d", i), {grant, gidx, gvalid, tmo},
            {tbl[i].grant, tbl[i].idx, tbl[i].valid, tbl[i].tmo});
    end

    // Test 6: asynchronous reset mid-packet, then arbitration restarts at ptr 0.
    req = 5'b00100; last = '0; ready = 1'b0;
    tick();
    check("pre_reset_grant", {grant, gidx, gvalid, tmo}, {5'b00100, 3'd2, 1'b1, 1'b0});
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {grant, gidx, gvalid, tmo}, 10'b0);
    #1;
    rst_n = 1'b1;
    req = 5'b01110;
    tick();
    check("post_reset_ptr0", {grant, gidx, gvalid, tmo}, {5'b00010, 3'd1, 1'b1, 1'b0});

    // Test 2: all five request 3-flit packets with ready high.
    req = '0;
    do_reset();
    req = 5'b11111; last = '0; ready = 1'b1;
    tick();
    for (int p = 0; p < 6; p++) begin
      for (int f = 0; f < 3; f++) begin
        logic [4:0] oh;
        oh = 5'd1 << (p % 5);
        check($sformatf("rr_p%0d_f%0d", p, f), {grant, gidx, gvalid, tmo},
              {oh, 3'(p % 5), 1'b1, 1'b0});
        last = (f == 2) ? oh : 5'b00000;
        tick();
      end
    end
    check("rr_after_wrap", {grant, gidx, gvalid, tmo}, {5'b00010, 3'd1, 1'b1, 1'b0});
    req = '0; last = '0; ready = 1'b0;
    tick();
    check("rr_withdraw_idle", {grant, gidx, gvalid, tmo}, 10'b0);

    // Test 5: watchdog on dut_b (MAX_HOLD=8), S granted and ready never asserted.
    req_b = 5'b11000; last_b = 5'b01000; ready_b = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("wd_hold%0d", c), {grant_b, gidx_b, gvalid_b, tmo_b},
            {5'b01000, 3'd3, 1'b1, 1'b0});
      tick();
    end
    check("wd_timeout", {grant_b, gidx_b, gvalid_b, tmo_b}, {5'b10000, 3'd4, 1'b1, 1'b1});
    tick();
    check("wd_pulse_end", {grant_b, gidx_b, gvalid_b, tmo_b}, {5'b10000, 3'd4, 1'b1, 1'b0});
    req_b = '0; last_b = '0;
    tick();
    check("wd_idle", {grant_b, gidx_b, gvalid_b, tmo_b}, 10'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
